// File: rtl/ger_i2c.sv
// rtl/ger_i2c.sv - I2C address-phase generator: START, 8 bits MSB-first, ACK slot, STOP.
// All bus outputs are registered from the next state so edges land exactly on phase boundaries.
module ger_i2c #(
    parameter int TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic [7:0] dado,
    output logic       sda,
    output logic       scl,
    output logic       ocupado,
    output logic       concluido
);

    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;

    typedef enum logic [3:0] {
        IDLE, INICIO, START, BIT_L0, BIT_L1, BIT_H,
        ACK_L0, ACK_L1, ACK_H, STOP_L0, STOP_L1, STOP_H, STOP_R, FIM
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          sda_nx, scl_nx;
    logic          last_phase;

    assign last_phase = (phase == PW'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda       <= 1'b1;
            scl       <= 1'b1;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            sda       <= sda_nx;
            scl       <= scl_nx;
            ocupado   <= (state_nx != IDLE);
            concluido <= (state_nx == FIM);
        end
    end

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        sda_nx     = sda;
        scl_nx     = 1'b1;

        if (state == IDLE) begin
            phase_nx = '0;
            if (inicio) begin
                state_nx   = INICIO;
                shreg_nx   = dado;
                bit_cnt_nx = 3'd7;
            end
        end else if (state == FIM) begin
            state_nx = IDLE;
            phase_nx = '0;
        end else if (!last_phase) begin
            phase_nx = phase + PW'(1);
        end else begin
            phase_nx = '0;
            case (state)
                INICIO:  state_nx = START;
                START:   state_nx = BIT_L0;
                BIT_L0:  state_nx = BIT_L1;
                BIT_L1:  state_nx = BIT_H;
                BIT_H: begin
                    if (bit_cnt != 3'd0) begin
                        bit_cnt_nx = bit_cnt - 3'd1;
                        state_nx   = BIT_L0;
                    end else begin
                        state_nx = ACK_L0;
                    end
                end
                ACK_L0:  state_nx = ACK_L1;
                ACK_L1:  state_nx = ACK_H;
                ACK_H:   state_nx = STOP_L0;
                STOP_L0: state_nx = STOP_L1;
                STOP_L1: state_nx = STOP_H;
                STOP_H:  state_nx = STOP_R;
                STOP_R:  state_nx = FIM;
                default: state_nx = IDLE;
            endcase
        end

        // Held-sda states keep the registered value; sda only moves while scl is low.
        case (state_nx)
            IDLE, INICIO, FIM: begin
                sda_nx = 1'b1;
                scl_nx = 1'b1;
            end
            START:   sda_nx = 1'b0;
            BIT_L0:  scl_nx = 1'b0;
            BIT_L1: begin
                scl_nx = 1'b0;
                sda_nx = shreg_nx[bit_cnt_nx];
            end
            BIT_H:   scl_nx = 1'b1;
            ACK_L0:  scl_nx = 1'b0;
            ACK_L1: begin
                scl_nx = 1'b0;
                sda_nx = 1'b0;
            end
            ACK_H:   scl_nx = 1'b1;
            STOP_L0: scl_nx = 1'b0;
            STOP_L1: begin
                scl_nx = 1'b0;
                sda_nx = 1'b0;
            end
            STOP_H:  sda_nx = 1'b0;
            STOP_R:  sda_nx = 1'b1;
            default: begin
                sda_nx = 1'b1;
                scl_nx = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ger_i2c.sv
// tb/tb_ger_i2c.sv - directed bench for ger_i2c at TICKS=4 and TICKS=1.
module tb_ger_i2c;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       inicio_a, inicio_b;
    logic [7:0] dado_a, dado_b;
    logic       sda_a, scl_a, ocup_a, conc_a;
    logic       sda_b, scl_b, ocup_b, conc_b;

    ger_i2c #(.TICKS(4)) dut (
        .clk(clk), .reset(reset), .inicio(inicio_a), .dado(dado_a),
        .sda(sda_a), .scl(scl_a), .ocupado(ocup_a), .concluido(conc_a)
    );

    ger_i2c #(.TICKS(1)) dut_t1 (
        .clk(clk), .reset(reset), .inicio(inicio_b), .dado(dado_b),
        .sda(sda_b), .scl(scl_b), .ocupado(ocup_b), .concluido(conc_b)
    );

    int checks = 0;
    int errors = 0;

    // Sample index n = number of rising edges since the accept edge (0 = accept edge).
    int   n_a, n_b;
    logic psda_a = 1'b1, pscl_a = 1'b1, pocup_a = 1'b0;
    logic psda_b = 1'b1, pscl_b = 1'b1, pocup_b = 1'b0;
    logic bits_a[$], bits_b[$];
    int   start_a[$], stop_a[$], concq_a[$], orise_a[$], ofall_a[$];
    int   start_b[$], stop_b[$], concq_b[$], orise_b[$], ofall_b[$];

    task automatic step();
        @(negedge clk);
        n_a++;
        n_b++;
        if (scl_a && !pscl_a) bits_a.push_back(sda_a);
        if (scl_a && pscl_a && (sda_a != psda_a)) begin
            if (!sda_a) start_a.push_back(n_a);
            else        stop_a.push_back(n_a);
        end
        if (conc_a) concq_a.push_back(n_a);
        if (ocup_a && !pocup_a) orise_a.push_back(n_a);
        if (!ocup_a && pocup_a) ofall_a.push_back(n_a);
        psda_a = sda_a; pscl_a = scl_a; pocup_a = ocup_a;
        if (scl_b && !pscl_b) bits_b.push_back(sda_b);
        if (scl_b && pscl_b && (sda_b != psda_b)) begin
            if (!sda_b) start_b.push_back(n_b);
            else        stop_b.push_back(n_b);
        end
        if (conc_b) concq_b.push_back(n_b);
        if (ocup_b && !pocup_b) orise_b.push_back(n_b);
        if (!ocup_b && pocup_b) ofall_b.push_back(n_b);
        psda_b = sda_b; pscl_b = scl_b; pocup_b = ocup_b;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic clear_a();
        n_a = -1;
        bits_a.delete(); start_a.delete(); stop_a.delete();
        concq_a.delete(); orise_a.delete(); ofall_a.delete();
    endtask

    task automatic clear_b();
        n_b = -1;
        bits_b.delete(); start_b.delete(); stop_b.delete();
        concq_b.delete(); orise_b.delete(); ofall_b.delete();
    endtask

    task automatic kick_a(input logic [7:0] d, input logic hold);
        dado_a   = d;
        inicio_a = 1'b1;
        clear_a();
        step();
        inicio_a = hold;
    endtask

    task automatic test_reset();
        reset = 1'b1; inicio_a = 1'b0; inicio_b = 1'b0; dado_a = 8'h00; dado_b = 8'h00;
        run(3);
        checks++; if (sda_a !== 1'b1)  begin errors++; $display("FAIL reset_sda: got %b expected 1", sda_a); end
        checks++; if (scl_a !== 1'b1)  begin errors++; $display("FAIL reset_scl: got %b expected 1", scl_a); end
        checks++; if (ocup_a !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b expected 0", ocup_a); end
        checks++; if (conc_a !== 1'b0) begin errors++; $display("FAIL reset_concluido: got %b expected 0", conc_a); end
        checks++; if ({sda_b, scl_b, ocup_b, conc_b} !== 4'b1100) begin errors++; $display("FAIL reset_t1: got %b expected 1100", {sda_b, scl_b, ocup_b, conc_b}); end
        reset = 1'b0;
        run(2);
        checks++; if ({sda_a, scl_a, ocup_a, conc_a} !== 4'b1100) begin errors++; $display("FAIL idle_after_reset: got %b expected 1100", {sda_a, scl_a, ocup_a, conc_a}); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        d = 8'hC8;
        kick_a(d, 1'b0);
        run(139);
        checks++; if (orise_a.size() < 1 || orise_a[0] !== 0) begin errors++; $display("FAIL basic_ocupado_rise: got size %0d expected rise at 0", orise_a.size()); end
        checks++; if (bits_a.size() !== 10) begin errors++; $display("FAIL basic_rise_count: got %0d expected 10", bits_a.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bits_a[i] !== d[7-i]) begin errors++; $display("FAIL basic_bit%0d: got %b expected %b", i, bits_a[i], d[7-i]); end
        end
        checks++; if (bits_a[8] !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", bits_a[8]); end
        checks++; if ({bits_a[0], bits_a[1], bits_a[2], bits_a[3], bits_a[4], bits_a[5], bits_a[6]} !== 7'b1100100) begin errors++; $display("FAIL basic_address: mismatch against 1100100"); end
        checks++; if (start_a.size() !== 1 || start_a[0] !== 4) begin errors++; $display("FAIL basic_start_edge: got %0d events, first %0d expected one at 4", start_a.size(), start_a[0]); end
        checks++; if (stop_a.size() !== 1 || stop_a[0] !== 128) begin errors++; $display("FAIL basic_stop_edge: got %0d events, first %0d expected one at 128", stop_a.size(), stop_a[0]); end
        checks++; if (concq_a.size() !== 1 || concq_a[0] !== 132) begin errors++; $display("FAIL basic_concluido: got %0d pulses, first %0d expected one at 132", concq_a.size(), concq_a[0]); end
        checks++; if (ofall_a.size() !== 1 || ofall_a[0] !== 133) begin errors++; $display("FAIL basic_ocupado_fall: got %0d falls, first %0d expected one at 133", ofall_a.size(), ofall_a[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        d1 = 8'hC9;
        d2 = 8'hAA;
        kick_a(d1, 1'b1);
        dado_a = d2;
        run(134);
        inicio_a = 1'b0;
        run(140);
        checks++; if (orise_a.size() !== 2 || orise_a[1] !== 134) begin errors++; $display("FAIL b2b_second_accept: got %0d rises, second %0d expected at 134", orise_a.size(), orise_a[1]); end
        checks++; if (ofall_a.size() < 1 || ofall_a[0] !== 133) begin errors++; $display("FAIL b2b_idle_gap: first fall %0d expected 133", ofall_a[0]); end
        checks++; if (start_a.size() !== 2 || start_a[1] !== 138) begin errors++; $display("FAIL b2b_second_start: got %0d starts, second %0d expected 138", start_a.size(), start_a[1]); end
        checks++; if (concq_a.size() !== 2 || concq_a[1] !== 266) begin errors++; $display("FAIL b2b_concluido: got %0d pulses, second %0d expected 266", concq_a.size(), concq_a[1]); end
        checks++; if (bits_a.size() !== 20) begin errors++; $display("FAIL b2b_rise_count: got %0d expected 20", bits_a.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bits_a[i] !== d1[7-i]) begin errors++; $display("FAIL b2b_first_bit%0d: got %b expected %b", i, bits_a[i], d1[7-i]); end
            checks++; if (bits_a[10+i] !== d2[7-i]) begin errors++; $display("FAIL b2b_second_bit%0d: got %b expected %b", i, bits_a[10+i], d2[7-i]); end
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] d;
        d = 8'h5A;
        kick_a(d, 1'b0);
        for (int i = 1; i <= 125; i++) begin
            step();
            if (i % 10 == 5) begin
                inicio_a = 1'b1;
                dado_a   = (i % 20 == 5) ? 8'h00 : 8'hFF;
            end else begin
                inicio_a = 1'b0;
            end
        end
        inicio_a = 1'b0;
        run(30);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bits_a[i] !== d[7-i]) begin errors++; $display("FAIL busy_bit%0d: got %b expected %b", i, bits_a[i], d[7-i]); end
        end
        checks++; if (concq_a.size() !== 1) begin errors++; $display("FAIL busy_concluido_count: got %0d expected 1", concq_a.size()); end
        checks++; if (orise_a.size() !== 1) begin errors++; $display("FAIL busy_accept_count: got %0d expected 1", orise_a.size()); end
        checks++; if (ocup_a !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got %b expected 0", ocup_a); end
    endtask

    task automatic test_reset_mid();
        kick_a(8'hC8, 1'b0);
        run(13);
        checks++; if (scl_a !== 1'b0) begin errors++; $display("FAIL midreset_in_bit_l1: scl got %b expected 0", scl_a); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({sda_a, scl_a, ocup_a} !== 3'b110) begin errors++; $display("FAIL midreset_outputs: got %b expected 110", {sda_a, scl_a, ocup_a}); end
        run(150);
        checks++; if (concq_a.size() !== 0) begin errors++; $display("FAIL midreset_no_concluido: got %0d pulses expected 0", concq_a.size()); end
        checks++; if ({sda_a, scl_a, ocup_a} !== 3'b110) begin errors++; $display("FAIL midreset_idle: got %b expected 110", {sda_a, scl_a, ocup_a}); end
        clear_a();
        inicio_a = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        inicio_a = 1'b0;
        checks++; if (ocup_a !== 1'b0) begin errors++; $display("FAIL reset_beats_inicio: ocupado got %b expected 0", ocup_a); end
        run(10);
        checks++; if (orise_a.size() !== 0) begin errors++; $display("FAIL reset_drops_request: got %0d accepts expected 0", orise_a.size()); end
    endtask

    task automatic test_ticks1();
        logic [7:0] d;
        d = 8'h01;
        dado_b   = d;
        inicio_b = 1'b1;
        clear_b();
        step();
        inicio_b = 1'b0;
        run(40);
        checks++; if (orise_b.size() !== 1 || orise_b[0] !== 0) begin errors++; $display("FAIL t1_accept: got %0d rises expected one at 0", orise_b.size()); end
        checks++; if (ofall_b.size() !== 1 || ofall_b[0] !== 34) begin errors++; $display("FAIL t1_length: fall at %0d expected 34", ofall_b[0]); end
        checks++; if (concq_b.size() !== 1 || concq_b[0] !== 33) begin errors++; $display("FAIL t1_concluido: got %0d pulses, first %0d expected one at 33", concq_b.size(), concq_b[0]); end
        checks++; if (start_b.size() + stop_b.size() !== 2) begin errors++; $display("FAIL t1_sda_while_scl_high: got %0d changes expected 2", start_b.size() + stop_b.size()); end
        checks++; if (start_b[0] !== 1) begin errors++; $display("FAIL t1_start_edge: got %0d expected 1", start_b[0]); end
        checks++; if (stop_b[0] !== 32) begin errors++; $display("FAIL t1_stop_edge: got %0d expected 32", stop_b[0]); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (bits_b[i] !== d[7-i]) begin errors++; $display("FAIL t1_bit%0d: got %b expected %b", i, bits_b[i], d[7-i]); end
        end
        checks++; if (bits_b[8] !== 1'b0) begin errors++; $display("FAIL t1_ack: got %b expected 0", bits_b[8]); end
    endtask

    initial begin
        n_a = 0;
        n_b = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_ticks1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
